ripple_count_sampler: RTL and testbench

- Downstream consumer of the free-running 3-bit ripple up counter. Brings its asynchronous, glitch-prone count into the system clock domain and filters out ripple transients, so only settled values are accepted.
- Flags wrap-around and illegal steps, and accumulates wrap events for the status logic that follows.
- All state sits in one clock domain. The ripple counter's own clock is unrelated to clk.

---
 rtl/ripple_count_sampler.sv | 116 +++++++++++
 tb/tb_ripple_count_sampler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// Samples a free-running ripple counter from another clock domain, accepts only settled values,
// and reports wrap-arounds and illegal steps between accepted values.
module ripple_count_sampler #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned WRAPS_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   cnt_in,
    input  logic               clr,
    output logic [WIDTH-1:0]   count_out,
    output logic               update,
    output logic               wrap,
    output logic               skip_err,
    output logic [WRAPS_W-1:0] wrap_cnt
);

    localparam int unsigned    StabW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES);
    localparam logic [WIDTH-1:0] CntMax  = '1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   sync_s;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [StabW-1:0]   stab_q, stab_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               update_q, update_d;
    logic               wrap_q, wrap_d;
    logic               skip_q, skip_d;
    logic [WRAPS_W-1:0] wcnt_q, wcnt_d;
    logic               accept;
    logic               step_ok;
    logic               wrap_evt;

    // Plain flop chain: nothing may look at cnt_in before the last stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= cnt_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (sync_s != cand_q) begin
            cand_d = sync_s;
            stab_d = StabW'(1);
        end else if (stab_q < StabMax) begin
            stab_d = stab_q + 1'b1;
        end
    end

    // Steps and wraps are judged against the value being replaced.
    assign accept   = (stab_q == StabMax) && (cand_q != count_q);
    assign step_ok  = (cand_q == WIDTH'(count_q + 1'b1));
    assign wrap_evt = (count_q == CntMax) && (cand_q == '0);

    always_comb begin
        count_d  = accept ? cand_q : count_q;
        update_d = accept;
        wrap_d   = accept && wrap_evt;
        skip_d   = clr ? 1'b0 : skip_q;
        wcnt_d   = clr ? '0 : wcnt_q;
        if (accept && !step_ok) begin
            skip_d = 1'b1;
        end
        if (accept && wrap_evt && (wcnt_d != '1)) begin
            wcnt_d = wcnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_q   <= '0;
            stab_q   <= '0;
            count_q  <= '0;
            update_q <= 1'b0;
            wrap_q   <= 1'b0;
            skip_q   <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            cand_q   <= cand_d;
            stab_q   <= stab_d;
            count_q  <= count_d;
            update_q <= update_d;
            wrap_q   <= wrap_d;
            skip_q   <= skip_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign count_out = count_q;
    assign update    = update_q;
    assign wrap      = wrap_q;
    assign skip_err  = skip_q;
    assign wrap_cnt  = wcnt_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Randomized bench for ripple_count_sampler; a sliding-window model over the per-edge input
// history predicts every output, cycle by cycle.
module tb_ripple_count_sampler;

    localparam int unsigned WIDTH   = 3;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned STABLE  = 3;
    localparam int unsigned WRAPS_W = 8;
    localparam int          Mod     = 1 << WIDTH;
    localparam int          WrapMax = (1 << WRAPS_W) - 1;
    localparam int          Hist    = 16;
    localparam int          VecW    = WIDTH + 3 + WRAPS_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               clr;
    logic [WIDTH-1:0]   cnt_in;
    logic [WIDTH-1:0]   count_out;
    logic               update;
    logic               wrap;
    logic               skip_err;
    logic [WRAPS_W-1:0] wrap_cnt;
    logic [VecW-1:0]    dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ripple_count_sampler #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .WRAPS_W      (WRAPS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .clr      (clr),
        .count_out(count_out),
        .update   (update),
        .wrap     (wrap),
        .skip_err (skip_err),
        .wrap_cnt (wrap_cnt)
    );

    assign dut_vec = {count_out, update, wrap, skip_err, wrap_cnt};

    // Reference model: history of what was presented at every clock edge.
    int  edge_no = 0;
    bit  h_rst [Hist];
    int  h_cnt [Hist];
    int  m_count = 0;
    int  m_wrapcnt = 0;
    bit  m_update = 0;
    bit  m_wrap = 0;
    bit  m_skip = 0;

    function automatic bit in_reset(int e);
        if (e < 0) return 1'b1;
        return h_rst[e % Hist];
    endfunction

    // Value the filter sees at edge e: the input captured SYNC edges earlier, or 0 if the pipe
    // was flushed by a reset edge in between.
    function automatic int filt_sample(int e);
        for (int k = 1; k <= int'(SYNC); k++) begin
            if (in_reset(e - k)) return 0;
        end
        return h_cnt[(e - int'(SYNC)) % Hist];
    endfunction

    function automatic logic [VecW-1:0] model_vec();
        return {WIDTH'(m_count), m_update, m_wrap, m_skip, WRAPS_W'(m_wrapcnt)};
    endfunction

    always @(posedge clk) begin
        int t;
        int v;
        bit ok;
        t = edge_no;
        h_rst[t % Hist] = !rst;
        h_cnt[t % Hist] = int'(cnt_in);
        if (!rst) begin
            m_count = 0; m_wrapcnt = 0; m_update = 0; m_wrap = 0; m_skip = 0;
        end else begin
            v  = filt_sample(t - 1);
            ok = 1'b1;
            for (int j = 1; j <= int'(STABLE); j++) begin
                if (in_reset(t - j) || filt_sample(t - j) != v) ok = 1'b0;
            end
            m_update = 0;
            m_wrap   = 0;
            if (clr) begin
                m_skip = 0;
                m_wrapcnt = 0;
            end
            if (ok && v != m_count) begin
                m_update = 1;
                if (v != (m_count + 1) % Mod) m_skip = 1;
                if (m_count == Mod - 1 && v == 0) begin
                    m_wrap = 1;
                    if (m_wrapcnt < WrapMax) m_wrapcnt++;
                end
                m_count = v;
            end
        end
        edge_no++;
    end

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; cnt_in = WIDTH'($urandom);
        repeat (3) @(negedge clk);
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, {VecW{1'b0}});
        end
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h expected %h", dut_vec, model_vec());
        end
        rst = 1'b1; cnt_in = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_first_step();
        int pulses = 0;
        int pulse_at = -1;
        cnt_in = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL first_step: got %h expected %h", dut_vec, model_vec());
            end
            if (update) begin
                pulses++; pulse_at = k;
            end
        end
        n_tests++;
        if (pulses != 1 || pulse_at != int'(SYNC + STABLE)) begin
            n_fail++;
            $display("FAIL first_latency: got %0d pulses at edge %0d, expected 1 at edge %0d",
                     pulses, pulse_at, SYNC + STABLE);
        end
        n_tests++;
        if ({count_out, skip_err, wrap} !== {3'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL first_state: got count=%0d skip=%b wrap=%b expected 1 0 0",
                     count_out, skip_err, wrap);
        end
    endtask

    task automatic test_walk();
        int ups = 0;
        int wraps = 0;
        rst = 1'b0; cnt_in = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        for (int v = 1; v <= Mod; v++) begin
            cnt_in = WIDTH'(v % Mod);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                n_tests++;
                if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL walk: got %h expected %h", dut_vec, model_vec());
                end
                ups += int'(update);
                wraps += int'(wrap);
            end
        end
        n_tests++;
        if (ups != Mod || wraps != 1 || wrap_cnt !== 8'd1 || skip_err !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_totals: got ups=%0d wraps=%0d wrap_cnt=%0d skip=%b expected %0d 1 1 0",
                     ups, wraps, wrap_cnt, skip_err, Mod);
        end
    endtask

    task automatic test_glitch();
        int ups = 0;
        int seq_v [4] = '{2, 0, 4, 4};
        int seq_n [4] = '{1, 2, 5, 5};
        cnt_in = 3;
        repeat (8) @(negedge clk);
        n_tests++;
        if (skip_err !== 1'b1 || count_out !== 3'd3) begin
            n_fail++;
            $display("FAIL glitch_preload: got count=%0d skip=%b expected 3 1", count_out, skip_err);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cnt_in = WIDTH'(seq_v[s]);
            for (int i = 0; i < seq_n[s]; i++) begin
                @(negedge clk);
                n_tests++;
                if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL glitch: got %h expected %h", dut_vec, model_vec());
                end
                ups += int'(update);
            end
        end
        n_tests++;
        if (ups != 1 || count_out !== 3'd4 || skip_err !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_result: got ups=%0d count=%0d skip=%b expected 1 4 0",
                     ups, count_out, skip_err);
        end
    endtask

    task automatic test_jump();
        cnt_in = 2;
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (count_out !== 3'd2 || skip_err !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_setup: got count=%0d skip=%b expected 2 0", count_out, skip_err);
        end
        cnt_in = 5;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL jump: got %h expected %h", dut_vec, model_vec());
            end
        end
        n_tests++;
        if (count_out !== 3'd5 || skip_err !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_sticky: got count=%0d skip=%b expected 5 1", count_out, skip_err);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (count_out !== 3'd5 || skip_err !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_clr: got count=%0d skip=%b expected 5 0", count_out, skip_err);
        end
    endtask

    task automatic test_wrap_sat();
        for (int n = 0; n < 300; n++) begin
            for (int v = 1; v <= Mod; v++) begin
                cnt_in = WIDTH'(v % Mod);
                repeat ($urandom_range(3, 6)) begin
                    @(negedge clk);
                    n_tests++;
                    if (dut_vec !== model_vec()) begin
                        n_fail++; $display("FAIL wrap_seq: got %h expected %h", dut_vec, model_vec());
                    end
                end
            end
        end
        n_tests++;
        if (wrap_cnt !== 8'd255) begin
            n_fail++; $display("FAIL wrap_saturate: got %0d expected 255", wrap_cnt);
        end
        cnt_in = WIDTH'(Mod - 1);
        repeat (8) @(negedge clk);
        cnt_in = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clr = (k == int'(SYNC + STABLE) - 1);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL wrap_clr_seq: got %h expected %h", dut_vec, model_vec());
            end
            if (k == int'(SYNC + STABLE)) begin
                n_tests++;
                if (wrap !== 1'b1 || wrap_cnt !== 8'd1) begin
                    n_fail++;
                    $display("FAIL wrap_clr: got wrap=%b wrap_cnt=%0d expected 1 1", wrap, wrap_cnt);
                end
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        cnt_in = 1;
        repeat (8) @(negedge clk);
        cnt_in = 2;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b0; cnt_in = 6;
        @(negedge clk);
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++; $display("FAIL reset_mid: got %h expected %h", dut_vec, {VecW{1'b0}});
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL reset_refill: got %h expected %h", dut_vec, model_vec());
            end
            if (k == int'(SYNC + STABLE)) begin
                n_tests++;
                if ({update, count_out, skip_err} !== {1'b1, 3'd6, 1'b1}) begin
                    n_fail++;
                    $display("FAIL reset_release: got upd=%b count=%0d skip=%b expected 1 6 1",
                             update, count_out, skip_err);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 200; s++) begin
            cnt_in = WIDTH'($urandom);
            rst = ($urandom_range(0, 63) != 0);
            repeat ($urandom_range(1, 5)) begin
                clr = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                rst = 1'b1;
                n_tests++;
                if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL random: got %h expected %h", dut_vec, model_vec());
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_walk();
        test_glitch();
        test_jump();
        test_wrap_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
